// File: rtl/bcd_to_binary_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// The master side produces BCD words and consumes binary results;
// the slave side (the converter) does the opposite.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);

  // Input (BCD) channel
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;

  // Output (binary) channel
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  // Word source / result sink
  modport master (
    output in_valid,
    output bcd_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bin_out,
    input  err
  );

  // Converter
  modport slave (
    input  in_valid,
    input  bcd_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bin_out,
    output err
  );

endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// A packed DIGITS-digit BCD word is loaded above a zeroed binary field and
// shifted right BIN_W times; after each shift every BCD digit that reads
// >= 8 has 3 subtracted. After the last shift the binary field holds the
// result. Words containing a digit > 9 still take the full BIN_W cycles,
// then report err=1 with a zero result.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  bcd_to_binary_seq_if.slave  bus
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SREG_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------

  // True when any packed digit holds a non-decimal code (A..F).
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      bad = bad | (bcd[4*d +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Per-digit correction: digits >= 8 lose 3. Digits are independent, and a
  // corrected digit is at least 8, so the subtraction never borrows.
  function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    logic [3:0]       dig;
    res = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      dig = bcd[4*d +: 4];
      res[4*d +: 4] = (dig >= 4'd8) ? (dig - 4'd3) : dig;
    end
    return res;
  endfunction

  // One reverse double-dabble iteration: shift right, then fix the BCD field.
  function automatic logic [SREG_W-1:0] dabble_step(input logic [SREG_W-1:0] sreg);
    logic [SREG_W-1:0] sh;
    sh = {1'b0, sreg[SREG_W-1:1]};
    return {correct_digits(sh[SREG_W-1:BIN_W]), sh[BIN_W-1:0]};
  endfunction

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  state_t              r_state;
  logic [SREG_W-1:0]   r_sreg;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err_q;
  logic [BIN_W-1:0]    r_bin_out;
  logic                r_err;
  logic                r_out_valid;
  logic                r_in_ready;

  state_t              w_state_nxt;
  logic [SREG_W-1:0]   w_sreg_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_err_q_nxt;
  logic [BIN_W-1:0]    w_bin_out_nxt;
  logic                w_err_nxt;
  logic                w_out_valid_nxt;
  logic                w_in_ready_nxt;
  logic [SREG_W-1:0]   w_step;

  assign w_step = dabble_step(r_sreg);

  // Next-state and next-output decode; every register holds unless a state says otherwise.
  always_comb begin
    w_state_nxt     = r_state;
    w_sreg_nxt      = r_sreg;
    w_cnt_nxt       = r_cnt;
    w_err_q_nxt     = r_err_q;
    w_bin_out_nxt   = r_bin_out;
    w_err_nxt       = r_err;
    w_out_valid_nxt = r_out_valid;
    w_in_ready_nxt  = r_in_ready;

    case (r_state)
      ST_IDLE: begin
        w_out_valid_nxt = 1'b0;
        if (bus.in_valid) begin
          // Accept: BCD word sits above an all-zero binary field.
          w_sreg_nxt     = {bus.bcd_in, {BIN_W{1'b0}}};
          w_err_q_nxt    = has_bad_digit(bus.bcd_in);
          w_cnt_nxt      = CNT_ZERO;
          w_err_nxt      = 1'b0;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = ST_CONV;
        end else begin
          w_in_ready_nxt = 1'b1;
        end
      end

      ST_CONV: begin
        w_sreg_nxt     = w_step;
        w_cnt_nxt      = r_cnt + CNT_ONE;
        w_in_ready_nxt = 1'b0;
        if (r_cnt == CNT_LAST) begin
          // Final shift: the binary field now holds the whole result.
          w_bin_out_nxt   = r_err_q ? {BIN_W{1'b0}} : w_step[BIN_W-1:0];
          w_err_nxt       = r_err_q;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = ST_HOLD;
        end else begin
          w_out_valid_nxt = 1'b0;
        end
      end

      ST_HOLD: begin
        w_in_ready_nxt = 1'b0;
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_out_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that drops any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sreg      <= {SREG_W{1'b0}};
      r_cnt       <= CNT_ZERO;
      r_err_q     <= 1'b0;
      r_bin_out   <= {BIN_W{1'b0}};
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err_q     <= w_err_q_nxt;
      r_bin_out   <= w_bin_out_nxt;
      r_err       <= w_err_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_in_ready  <= w_in_ready_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.bin_out   = r_bin_out;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq (DIGITS=3, BIN_W=10).
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   cyc_cnt;
  int   acc_q[$];

  bcd_to_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and log of accepting edges.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc_q.push_back(cyc_cnt);
  end

  // Reference: decimal weighting of the digits; zero result if any digit > 9.
  function automatic bit ref_err(input logic [11:0] bcd);
    return (bcd[3:0] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[11:8] > 4'd9);
  endfunction

  function automatic int ref_bin(input logic [11:0] bcd);
    if (ref_err(bcd)) return 0;
    return int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge. Sends one word, checks
  // latency/result, optionally stalls the result for hold_cyc cycles while
  // offering a stray input word, then completes the output handshake.
  task automatic convert(input logic [11:0] bcd, input int exp_bin, input bit exp_err,
                         input string tag, input int hold_cyc);
    int cyc;
    cyc = 0;
    while (bus.in_ready !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.bcd_in   = bcd;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.bcd_in   = 12'hFFF;
    check({tag, "_busy"}, bus.in_ready, 0);
    check({tag, "_err_clr"}, bus.err, 0);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, cyc, BIN_W);
    check({tag, "_bin"}, bus.bin_out, exp_bin);
    check({tag, "_err"}, bus.err, exp_err);
    for (int k = 0; k < hold_cyc; k++) begin
      bus.in_valid = 1'b1;
      bus.bcd_in   = 12'h555;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_bin"}, bus.bin_out, exp_bin);
      check({tag, "_hold_err"}, bus.err, exp_err);
      check({tag, "_hold_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_released"}, bus.out_valid, 0);
  endtask

  initial begin
    int cyc;
    int n0;
    int spacing;
    logic [11:0] bcd;

    n_assert      = 0;
    n_fail        = 0;
    cyc_cnt       = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = 12'h000;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_bin", bus.bin_out, 0);
    check("rst_err", bus.err, 0);

    // Main function and an all-nines maximum
    convert(12'h999, 999, 1'b0, "c999", 0);
    convert(12'h000, 0,   1'b0, "c000", 0);
    convert(12'h255, 255, 1'b0, "c255", 0);
    convert(12'h100, 100, 1'b0, "c100", 0);

    // Invalid digit: error flag, zero result, same latency; next word clears err
    convert(12'h1A5, 0, 1'b1, "c1A5", 0);
    convert(12'h007, 7, 1'b0, "c007", 0);
    convert(12'hF00, 0, 1'b1, "cF00", 0);

    // Backpressure: result held for 5 cycles, stray input ignored
    convert(12'h321, 321, 1'b0, "bp321", 5);
    @(posedge clk); #1;
    check("bp_idle_ready", bus.in_ready, 1);
    check("bp_no_accept", bus.out_valid, 0);

    // Reset in the middle of a conversion (cnt = 4)
    bus.in_valid = 1'b1;
    bus.bcd_in   = 12'h876;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_bin", bus.bin_out, 0);
    check("mid_rst_err", bus.err, 0);
    repeat (12) @(posedge clk);
    #1 check("mid_rst_dropped", bus.out_valid, 0);
    convert(12'h042, 42, 1'b0, "c042", 0);

    // Back-to-back with out_ready held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.bcd_in    = 12'h123;
    n0  = acc_q.size();
    cyc = 0;
    while (acc_q.size() == n0 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    bus.bcd_in = 12'h987;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check("b2b_first", bus.bin_out, 123);
    cyc = 0;
    while (acc_q.size() < n0 + 2 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    bus.in_valid = 1'b0;
    spacing = (acc_q.size() >= n0 + 2) ? (acc_q[n0+1] - acc_q[n0]) : -1;
    check("b2b_spacing", spacing, BIN_W + 2);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check("b2b_second", bus.bin_out, 987);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("b2b_done", bus.out_valid, 0);

    // Exhaustive legal sweep against the reference
    for (int i = 0; i < 1000; i++) begin
      bcd = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      convert(bcd, ref_bin(bcd), ref_err(bcd), "sweep", 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
